complex_matvec_scheduler: RTL and testbench
===========================================

// Module: complex_matvec_scheduler
// PURPOSE
//  Sequences a full complex matrix-by-vector product through the 3-lane complex row-by-vector datapath
//  (192-bit operand beats = 3 x 64-bit complex words, fully pipelined, one beat/cycle max).
//  Walks rows and chunks, drives operand-memory reads and the datapath start strobe, and tracks beats in flight.
//  Emits per-beat accumulate controls (clear/last/row) to the downstream complex accumulator.
//  Pulses done when the last row's final partial sum leaves the pipeline.
// PARAMETERS
//  N_ROWS          24  rows in matrix
//  CHUNKS_PER_ROW  8   192-bit beats per row (>=1)
//  PIPE_LATENCY    9   cycles from dp_start to that beat's partial sum at datapath output (>=1)
//  ISSUE_GAP       1   min cycles between consecutive issues (1 = back-to-back)
//  ADDR_W          16  operand-memory address width
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          asynchronous, active-high
//  start         in   1          begin run; accepted only in IDLE
//  hold          in   1          stall issue (operand not ready); no effect on beats in flight
//  busy          out  1          run in progress
//  done          out  1          1-cycle pulse at end of run
//  mem_rd_en     out  1          operand read strobe (row and vector memories, 1-cycle read latency)
//  mem_row_addr  out  ADDR_W     matrix address = row*CHUNKS_PER_ROW + chunk
//  mem_vec_addr  out  ADDR_W     vector address = chunk
//  dp_start      out  1          datapath start strobe, = mem_rd_en delayed 1 cycle (aligned with read data)
//  acc_valid     out  1          partial sum valid at datapath output
//  acc_clear     out  1          with acc_valid: first chunk of row, accumulator loads instead of adds
//  acc_last      out  1          with acc_valid: final chunk of row, accumulator result is complete
//  acc_row       out  ROW_W      row of current partial sum; ROW_W = max(1,$clog2(N_ROWS))
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, tag pipeline cleared; async, any cycle, no done emitted.
//  - FSM: IDLE -(start)-> ISSUE; ISSUE -(last beat issued)-> DRAIN; DRAIN -(final tag exits)-> IDLE.
//  - busy: registered, 1 from cycle after start accepted through done cycle inclusive.
//  - start while busy (incl. done cycle): ignored. A start in the first cycle back in IDLE is accepted.
//  - Issue (combinational): mem_rd_en = (state==ISSUE) & ~hold & gap_ok.
//    - gap_ok: >=ISSUE_GAP cycles since previous issue; first issue of a run is always ok.
//  - Addresses are valid whenever mem_rd_en=1; chunk advances only on issue.
//    - chunk wraps CHUNKS_PER_ROW-1 -> 0 with row+1.
//    - Issue of row N_ROWS-1 / chunk CHUNKS_PER_ROW-1 moves to DRAIN.
//  - hold: freezes counters and gap timer, suppresses mem_rd_en. hold during DRAIN is ignored.
//    hold=1 on the accept cycle is allowed.
//  - Tag pipeline: each issue pushes {first, last, row} into a PIPE_LATENCY+1 deep shift register.
//    - Latency: acc_* = mem_rd_en delayed PIPE_LATENCY+1 cycles, i.e. dp_start delayed PIPE_LATENCY.
//    - first = (chunk==0); last = (chunk==CHUNKS_PER_ROW-1).
//    - CHUNKS_PER_ROW=1: every beat has clear and last.
//  - done: registered, 1 cycle after acc_valid&acc_last for row N_ROWS-1; busy falls the next cycle.
//  - Addresses are truncated to ADDR_W. The integrator sizes ADDR_W >= clog2(N_ROWS*CHUNKS_PER_ROW).
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined:
//    - adds ports perf_cycles out 32 and perf_hold_cycles out 32.
//    - Internal counts: cycles from accept cycle to done inclusive, and cycles in ISSUE with hold=1.
//    - Both latched to the ports at done; they hold until the next done. Reset clears them to 0.
//    - Counters saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent. All other behaviour is identical.
// TESTING (N_ROWS=2, CHUNKS_PER_ROW=3, PIPE_LATENCY=9, ISSUE_GAP=1 unless noted; start pulse cycle 0)
//  1 Basic run:
//    - mem_rd_en cycles 1-6, row_addr 0..5, vec_addr 0,1,2,0,1,2; dp_start cycles 2-7.
//    - acc_valid 11-16; clear at 11,14; last at 13(row0),16(row1); done at 17; busy 1-17.
//  2 hold=1 cycles 3-4:
//    - no rd_en at 3-4; row_addr 2 issued at cycle 5; last issue cycle 8; done at 19.
//    - with SCHED_PERF_CNT_EN: perf_cycles=20, perf_hold_cycles=2.
//  3 ISSUE_GAP=2:
//    - rd_en cycles 1,3,5,7,9,11; acc_valid 11,13,...,21; done at 22.
//  4 CHUNKS_PER_ROW=1, N_ROWS=3:
//    - rd_en 1-3; acc_valid 11-13 each with clear=last=1; acc_row 0,1,2; done at 14.
//  5 start re-pulsed at cycle 4 and at done cycle 17: ignored.
//    - start at 18 is accepted: rd_en 19-24.
//  6 reset asserted mid-cycle at cycle 8, released at 10:
//    - all outputs 0 immediately; no acc_valid/done afterwards.
//    - next start at cycle 12 runs a clean sequence (rd_en 13-18, done 29).

Source files
------------

// File: rtl/complex_matvec_scheduler.sv
// Walks rows/chunks of a complex mat-vec product, issues operand reads, and tags beats through the datapath latency.
// Optional run/hold cycle counters under SCHED_PERF_CNT_EN; hold stalls issue only, beats in flight always drain.
module complex_matvec_scheduler #(
    parameter int N_ROWS         = 24,
    parameter int CHUNKS_PER_ROW = 8,
    parameter int PIPE_LATENCY   = 9,
    parameter int ISSUE_GAP      = 1,
    parameter int ADDR_W         = 16,
    localparam int ROW_W         = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_row_addr,
    output logic [ADDR_W-1:0] mem_vec_addr,
    output logic              dp_start,
    output logic              acc_valid,
    output logic              acc_clear,
    output logic              acc_last,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_hold_cycles,
`endif
    output logic [ROW_W-1:0]  acc_row
);

    localparam int CHK_W = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
    localparam int GAP_W = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic [ROW_W-1:0] row;
    } tag_t;

    state_t           state_q;
    logic [ROW_W-1:0] row_q;
    logic [CHK_W-1:0] chunk_q;
    logic [GAP_W-1:0] gap_q;
    logic             busy_q;
    logic             done_q;
    tag_t             tag_q [0:PIPE_LATENCY];

    logic gap_ok;
    logic rd_en;
    logic last_chunk;
    logic last_row;
    logic final_exit;
    tag_t tag_d;

    // gap_q saturates at ISSUE_GAP-1; preset there on accept so the first issue is never delayed
    assign gap_ok     = (gap_q == GAP_W'(ISSUE_GAP - 1));
    assign rd_en      = (state_q == ISSUE) & ~hold & gap_ok;
    assign last_chunk = (chunk_q == CHK_W'(CHUNKS_PER_ROW - 1));
    assign last_row   = (row_q == ROW_W'(N_ROWS - 1));

    always_comb begin
        tag_d       = '0;
        tag_d.vld   = rd_en;
        tag_d.first = rd_en & (chunk_q == '0);
        tag_d.last  = rd_en & last_chunk;
        tag_d.row   = rd_en ? row_q : '0;
    end

    assign final_exit = tag_q[PIPE_LATENCY].vld & tag_q[PIPE_LATENCY].last &
                        (tag_q[PIPE_LATENCY].row == ROW_W'(N_ROWS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            chunk_q <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i <= PIPE_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= PIPE_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            done_q <= final_exit;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        chunk_q <= '0;
                        gap_q   <= GAP_W'(ISSUE_GAP - 1);
                    end
                end
                ISSUE: begin
                    if (rd_en) begin
                        gap_q <= '0;
                        if (last_chunk) begin
                            chunk_q <= '0;
                            if (last_row) begin
                                row_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            chunk_q <= chunk_q + 1'b1;
                        end
                    end else if (!hold && !gap_ok) begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // done_q is high for exactly one cycle; busy covers it, then we release
                    if (done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_rd_en    = rd_en;
    assign mem_row_addr = ADDR_W'(32'(row_q) * 32'(CHUNKS_PER_ROW) + 32'(chunk_q));
    assign mem_vec_addr = ADDR_W'(chunk_q);
    assign dp_start     = tag_q[0].vld;
    assign acc_valid    = tag_q[PIPE_LATENCY].vld;
    assign acc_clear    = tag_q[PIPE_LATENCY].first;
    assign acc_last     = tag_q[PIPE_LATENCY].last;
    assign acc_row      = tag_q[PIPE_LATENCY].row;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] hcnt_q;
    logic [31:0] perf_cyc_q;
    logic [31:0] perf_hold_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // cyc_q equals the cycle index since accept, so the done-cycle latch adds one for inclusivity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q       <= '0;
            hcnt_q      <= '0;
            perf_cyc_q  <= '0;
            perf_hold_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                cyc_q  <= 32'd1;
                hcnt_q <= '0;
            end else begin
                if (busy_q && !done_q) cyc_q <= sat_inc(cyc_q);
                if (state_q == ISSUE && hold) hcnt_q <= sat_inc(hcnt_q);
            end
            if (done_q) begin
                perf_cyc_q  <= sat_inc(cyc_q);
                perf_hold_q <= hcnt_q;
            end
        end
    end

    assign perf_cycles      = perf_cyc_q;
    assign perf_hold_cycles = perf_hold_q;
`endif

endmodule

// File: tb/tb_complex_matvec_scheduler.sv
// Directed bench: cycle table for basic and hold runs, hand sequences for gap, single-chunk, restart and reset.
module tb_complex_matvec_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT A: N_ROWS=2, CHUNKS_PER_ROW=3, PIPE_LATENCY=9, ISSUE_GAP=1
    logic start_a = 1'b0, hold_a = 1'b0;
    logic busy_a, done_a, rd_a, dp_a, av_a, clr_a, lst_a;
    logic [15:0] ra_a, va_a;
    logic [0:0] row_a;
    // DUT G: ISSUE_GAP=2
    logic start_g = 1'b0, hold_g = 1'b0;
    logic busy_g, done_g, rd_g, dp_g, av_g, clr_g, lst_g;
    logic [15:0] ra_g, va_g;
    logic [0:0] row_g;
    // DUT C: CHUNKS_PER_ROW=1, N_ROWS=3
    logic start_c = 1'b0, hold_c = 1'b0;
    logic busy_c, done_c, rd_c, dp_c, av_c, clr_c, lst_c;
    logic [15:0] ra_c, va_c;
    logic [1:0] row_c;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] pc_a, ph_a, pc_g, ph_g, pc_c, ph_c;
`endif

    complex_matvec_scheduler #(.N_ROWS(2), .CHUNKS_PER_ROW(3), .PIPE_LATENCY(9), .ISSUE_GAP(1), .ADDR_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .hold(hold_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_row_addr(ra_a), .mem_vec_addr(va_a), .dp_start(dp_a),
        .acc_valid(av_a), .acc_clear(clr_a), .acc_last(lst_a),
`ifdef SCHED_PERF_CNT_EN
        .perf_cycles(pc_a), .perf_hold_cycles(ph_a),
`endif
        .acc_row(row_a));

    complex_matvec_scheduler #(.N_ROWS(2), .CHUNKS_PER_ROW(3), .PIPE_LATENCY(9), .ISSUE_GAP(2), .ADDR_W(16)) dut_g (
        .clk(clk), .reset(reset), .start(start_g), .hold(hold_g), .busy(busy_g), .done(done_g),
        .mem_rd_en(rd_g), .mem_row_addr(ra_g), .mem_vec_addr(va_g), .dp_start(dp_g),
        .acc_valid(av_g), .acc_clear(clr_g), .acc_last(lst_g),
`ifdef SCHED_PERF_CNT_EN
        .perf_cycles(pc_g), .perf_hold_cycles(ph_g),
`endif
        .acc_row(row_g));

    complex_matvec_scheduler #(.N_ROWS(3), .CHUNKS_PER_ROW(1), .PIPE_LATENCY(9), .ISSUE_GAP(1), .ADDR_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .hold(hold_c), .busy(busy_c), .done(done_c),
        .mem_rd_en(rd_c), .mem_row_addr(ra_c), .mem_vec_addr(va_c), .dp_start(dp_c),
        .acc_valid(av_c), .acc_clear(clr_c), .acc_last(lst_c),
`ifdef SCHED_PERF_CNT_EN
        .perf_cycles(pc_c), .perf_hold_cycles(ph_c),
`endif
        .acc_row(row_c));

    typedef struct {
        logic        st;
        logic        hd;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // expected {busy,done,rd_en,row_addr,vec_addr,dp_start,acc_valid,clear,last,row}
    function automatic vec_t mk(input logic s, h, b, d, r, input int ra, va,
                                input logic dp, av, cl, ls, rw);
        vec_t v;
        v.st  = s;
        v.hd  = h;
        v.exp = {b, d, r, 16'(ra), 16'(va), dp, av, cl, ls, rw};
        return v;
    endfunction

    function automatic logic [39:0] pack_a();
        return {busy_a, done_a, rd_a, ra_a, va_a, dp_a, av_a, clr_a, lst_a, row_a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] m_rd, m_av, m_dn, m_bz, m_clr, m_lst, n_rd, n_av, n_dn;
    logic [5:0]  c_rows;
    logic [39:0] got;

    initial begin
        // basic run (cycles 0..18)
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,1,1, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,2,2, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,3,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,4,1, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,5,2, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 1,0,0,0,0));
        for (int i = 8; i <= 10; i++) tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,1,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,1,0,1));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,0,1));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,1,1));
        tbl.push_back(mk(0,0, 1,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0,0));
        // hold at cycles 3-4 (cycles 0..20)
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,1,1, 1,0,0,0,0));
        tbl.push_back(mk(0,1, 1,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,1, 1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,2,2, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,3,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,4,1, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,1,5,2, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,1,0));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,1,0,1));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,0,1));
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,1,0,1,1));
        tbl.push_back(mk(0,0, 1,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0,0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a", 64'(pack_a()), 64'd0);
        chk("reset_g", 64'({busy_g, done_g, rd_g, dp_g, av_g}), 64'd0);
        chk("reset_c", 64'({busy_c, done_c, rd_c, dp_c, av_c}), 64'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        foreach (tbl[i]) begin
            start_a = tbl[i].st;
            hold_a  = tbl[i].hd;
            @(negedge clk);
            got = pack_a();
            if (!tbl[i].exp[37]) got[36:5] = '0;
            chk($sformatf("vec%0d", i), 64'(got), 64'(tbl[i].exp));
            next_cycle();
        end
        start_a = 1'b0;
        hold_a  = 1'b0;
`ifdef SCHED_PERF_CNT_EN
        chk("perf_cycles", 64'(pc_a), 64'd20);
        chk("perf_hold_cycles", 64'(ph_a), 64'd2);
`endif

        // ISSUE_GAP=2 and single-chunk rows, run side by side
        m_rd = '0; m_av = '0; m_dn = '0; n_rd = '0; n_av = '0; n_dn = '0;
        m_clr = '0; m_lst = '0; c_rows = '0;
        for (int c = 0; c < 30; c++) begin
            start_g = (c == 0);
            start_c = (c == 0);
            @(negedge clk);
            m_rd[c] = rd_g; m_av[c] = av_g; m_dn[c] = done_g;
            n_rd[c] = rd_c; n_av[c] = av_c; n_dn[c] = done_c;
            m_clr[c] = av_c & clr_c; m_lst[c] = av_c & lst_c;
            if (av_c) c_rows = {c_rows[3:0], row_c};
            next_cycle();
        end
        start_g = 1'b0;
        start_c = 1'b0;
        chk("gap_rd", m_rd, 64'h0000_0AAA);
        chk("gap_av", m_av, 64'h002A_A800);
        chk("gap_done", m_dn, 64'h0040_0000);
        chk("c1_rd", n_rd, 64'h0000_000E);
        chk("c1_av", n_av, 64'h0000_3800);
        chk("c1_clear", m_clr, 64'h0000_3800);
        chk("c1_last", m_lst, 64'h0000_3800);
        chk("c1_rows", 64'(c_rows), 64'h06);
        chk("c1_done", n_dn, 64'h0000_4000);

        // restart attempts while busy, on done, and just after done
        m_rd = '0; m_dn = '0; m_bz = '0;
        for (int c = 0; c < 40; c++) begin
            start_a = (c == 0) || (c == 4) || (c == 17) || (c == 18);
            @(negedge clk);
            m_rd[c] = rd_a; m_dn[c] = done_a; m_bz[c] = busy_a;
            next_cycle();
        end
        start_a = 1'b0;
        chk("restart_rd", m_rd, 64'h0000_0000_01F8_007E);
        chk("restart_done", m_dn, 64'h0000_0008_0002_0000);
        chk("restart_busy", m_bz, 64'h0000_000F_FFFB_FFFE);

        // async reset in the middle of a run
        m_rd = '0; m_av = '0; m_dn = '0;
        for (int c = 0; c < 40; c++) begin
            start_a = (c == 0) || (c == 12);
            if (c == 8) reset = 1'b1;
            if (c == 10) reset = 1'b0;
            @(negedge clk);
            if (c == 8) chk("midreset_outputs", 64'(pack_a()), 64'd0);
            m_rd[c] = rd_a; m_av[c] = av_a; m_dn[c] = done_a;
            next_cycle();
        end
        start_a = 1'b0;
        chk("midreset_rd", m_rd, 64'h0007_E07E);
        chk("midreset_av", m_av, 64'h1F80_0000);
        chk("midreset_done", m_dn, 64'h2000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
